// File: rtl/ola_out_buffer.sv
// Output buffer behind the overlap-add stage: circular FIFO filled in frame bursts,
// drained one rescaled/saturated sample per audio tick, gated by a prime/run FSM.
`timescale 1ns/1ps
module ola_out_buffer #(
  parameter int DWIDTH      = 32,
  parameter int OWIDTH      = 16,
  parameter int SHIFT       = 15,
  parameter int AWIDTH      = 7,
  parameter int PRIME_LEVEL = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [DWIDTH-1:0] din,
  input  logic                     din_valid,
  input  logic                     sample_tick,
  input  logic                     clr_flags,
  output logic        [OWIDTH-1:0] dout,
  output logic                     dout_valid,
  output logic        [AWIDTH:0]   level,
  output logic                     running,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [AWIDTH:0] LVL_FULL  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LVL_PRIME = (AWIDTH+1)'(PRIME_LEVEL);

  localparam logic signed [DWIDTH-1:0] SAT_MAX = DWIDTH'((1 << (OWIDTH-1)) - 1);
  localparam logic signed [DWIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Arithmetic shift down to codec scale, clamping anything outside the OWIDTH range.
  function automatic logic [OWIDTH-1:0] scale_sat(input logic signed [DWIDTH-1:0] x);
    logic signed [DWIDTH-1:0] s;
    s = x >>> SHIFT;
    if (s > SAT_MAX) begin
      return SAT_MAX[OWIDTH-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[OWIDTH-1:0];
    end else begin
      return s[OWIDTH-1:0];
    end
  endfunction

  logic signed [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic [0:0]        state_q, state_d;
  logic [OWIDTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic empty_s, full_s, is_run_s;
  logic pop_s, push_s, oflow_evt_s, uflow_evt_s;
  logic signed [DWIDTH-1:0] rd_data_s;

  assign empty_s   = (level_q == '0);
  assign full_s    = (level_q == LVL_FULL);
  assign is_run_s  = (state_q == ST_RUN);
  assign rd_data_s = mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign pop_s       = is_run_s & sample_tick & ~empty_s;
  assign uflow_evt_s = is_run_s & sample_tick & empty_s;
  assign push_s      = din_valid & (~full_s | pop_s);
  assign oflow_evt_s = din_valid & full_s & ~pop_s;

  // Next-state for pointers, occupancy, FSM, output sample and sticky flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (AWIDTH+1)'(1);
      2'b01:   level_d = level_q - (AWIDTH+1)'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_PRIME: begin
        if (level_q >= LVL_PRIME) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (uflow_evt_s) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_PRIME;
    endcase

    if (pop_s) begin
      dout_d       = scale_sat(rd_data_s);
      dout_valid_d = 1'b1;
    end else if (uflow_evt_s) begin
      dout_d       = '0;
      dout_valid_d = 1'b1;
    end else begin
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
    end

    // Set events take priority over a coincident clear.
    if (oflow_evt_s) begin
      overflow_d = 1'b1;
    end else if (clr_flags) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (uflow_evt_s) begin
      underflow_d = 1'b1;
    end else if (clr_flags) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= ST_PRIME;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign running    = is_run_s;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_ola_out_buffer.sv
// Scoreboard bench for ola_out_buffer: stimulus queues expected samples, a negedge
// monitor pops and compares each dout_valid pulse.
`timescale 1ns/1ps
module tb_ola_out_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] din;
  logic        din_valid;
  logic        sample_tick;
  logic        clr_flags;
  logic [15:0] dout;
  logic        dout_valid;
  logic [7:0]  level;
  logic        running;
  logic        overflow;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  ola_out_buffer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .din         (din),
    .din_valid   (din_valid),
    .sample_tick (sample_tick),
    .clr_flags   (clr_flags),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .level       (level),
    .running     (running),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid: got dout_valid=1 (dout=%0h) expected no output at %0t", dout, $time);
      end else begin
        e = sb.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    sample_tick = 1'b0;
    clr_flags   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
  endtask

  task automatic tick(input logic [15:0] e);
    sample_tick = 1'b1;
    sb.push_back(e);
    step();
  endtask

  task automatic tick_none();
    sample_tick = 1'b1;
    step();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    sb.delete();
    din_valid   = 1'b0;
    sample_tick = 1'b0;
    clr_flags   = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();
  endtask

  initial begin
    int wcnt;
    int rcnt;
    int c;
    n_rst = 1'b0; din = 32'h0; din_valid = 1'b0; sample_tick = 1'b0; clr_flags = 1'b0;
    do_reset();

    // Reset state, then idle ticks in PRIME
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_level", {24'h0, level}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_underflow", {31'h0, underflow}, 32'h0);
    repeat (20) tick_none();
    chk("idle_dout", {16'h0, dout}, 32'h0);
    chk("idle_running", {31'h0, running}, 32'h0);
    chk("idle_level", {24'h0, level}, 32'h0);

    // Prime with 64 and drain back-to-back
    for (int k = 0; k < 64; k++) wr(32'(k) << 15);
    chk("prime_level", {24'h0, level}, 32'd64);
    chk("prime_running_lag", {31'h0, running}, 32'h0);
    step();
    chk("prime_running", {31'h0, running}, 32'h1);
    for (int k = 0; k < 64; k++) tick(16'(k));
    step(); step();
    chk("drain_level", {24'h0, level}, 32'h0);
    chk("drain_running", {31'h0, running}, 32'h1);

    // Saturation corners
    wr(32'h7FFF_FFFF); wr(32'h8000_0000); wr(32'h0000_8000); wr(32'hFFFF_8000);
    for (int k = 0; k < 60; k++) wr(32'(100 + k) << 15);
    tick(16'h7FFF); tick(16'h8000); tick(16'h0001); tick(16'hFFFF);
    for (int k = 0; k < 60; k++) tick(16'(100 + k));
    step(); step();
    chk("sat_level", {24'h0, level}, 32'h0);
    chk("sat_underflow", {31'h0, underflow}, 32'h0);

    // Overflow: 130 writes into 128 slots
    do_reset();
    for (int k = 1; k <= 130; k++) wr(32'(k) << 15);
    chk("ovf_level", {24'h0, level}, 32'd128);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    clr_flags = 1'b1;
    step();
    chk("ovf_clr", {31'h0, overflow}, 32'h0);
    din = 32'(999) << 15; din_valid = 1'b1; sample_tick = 1'b1; sb.push_back(16'd1);
    step();
    chk("full_pushpop_level", {24'h0, level}, 32'd128);
    chk("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
    din = 32'(777) << 15; din_valid = 1'b1; clr_flags = 1'b1;
    step();
    chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
    clr_flags = 1'b1;
    step();
    for (int k = 2; k <= 128; k++) tick(16'(k));
    tick(16'd999);
    step(); step();
    chk("ovf_drain_level", {24'h0, level}, 32'h0);
    chk("ovf_drain_flag", {31'h0, overflow}, 32'h0);

    // Underflow: 65 ticks on 64 samples
    do_reset();
    for (int k = 0; k < 64; k++) wr(32'(200 + k) << 15);
    step();
    chk("udf_running", {31'h0, running}, 32'h1);
    for (int k = 0; k < 64; k++) tick(16'(200 + k));
    tick(16'h0);
    chk("udf_flag", {31'h0, underflow}, 32'h1);
    chk("udf_running_off", {31'h0, running}, 32'h0);
    chk("udf_dout", {16'h0, dout}, 32'h0);
    chk("udf_level", {24'h0, level}, 32'h0);
    repeat (5) tick_none();
    chk("udf_sticky", {31'h0, underflow}, 32'h1);
    for (int k = 0; k < 63; k++) wr(32'(300 + k) << 15);
    repeat (3) tick_none();
    chk("udf_reprime_63", {31'h0, running}, 32'h0);
    wr(32'(363) << 15);
    step();
    chk("udf_reprime_64", {31'h0, running}, 32'h1);
    for (int k = 0; k < 64; k++) tick(16'(300 + k));
    clr_flags = 1'b1;
    step();
    chk("udf_clr", {31'h0, underflow}, 32'h0);

    // Wrap: 300 samples, bursty writes at the tick rate
    do_reset();
    for (int k = 0; k < 64; k++) wr(32'(k) << 15);
    step();
    wcnt = 64; rcnt = 0; c = 0;
    while (wcnt < 300) begin
      if ((c % 9) < 3) begin
        din = 32'(wcnt) << 15; din_valid = 1'b1; wcnt++;
      end
      if ((c % 3) == 0) begin
        sample_tick = 1'b1; sb.push_back(16'(rcnt)); rcnt++;
      end
      step();
      c++;
    end
    chk("wrap_level", {24'h0, level}, 32'(wcnt - rcnt));
    chk("wrap_overflow", {31'h0, overflow}, 32'h0);
    chk("wrap_underflow", {31'h0, underflow}, 32'h0);
    while (wcnt - rcnt > 10) begin
      tick(16'(rcnt));
      rcnt++;
    end

    // Reset lands while a dout_valid pulse is in flight
    sample_tick = 1'b1;
    sb.push_back(16'(rcnt));
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_dout", {16'h0, dout}, 32'h0);
    chk("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("mid_rst_level", {24'h0, level}, 32'h0);
    chk("mid_rst_running", {31'h0, running}, 32'h0);
    chk("mid_rst_flags", {30'h0, overflow, underflow}, 32'h0);
    sample_tick = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();
    repeat (3) tick_none();
    chk("post_rst_level", {24'h0, level}, 32'h0);
    chk("post_rst_running", {31'h0, running}, 32'h0);
    step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ola_out_buffer.md
Name: ola_out_buffer

Overview:
- Downstream consumer of the overlap-add stage. Captures each overlap-added sample (32-bit signed) on the cycles its valid flag (ready_hn2finish) is high and stores it in a circular FIFO.
- Drains one sample per audio-rate tick, rescaled and saturated to codec width. Output goes to the DAC/AXI-stream side of the noise-cancelling core.
- A prime/run state machine absorbs frame-burst vs. sample-rate mismatch.

Parameters:
- DWIDTH, 32, input sample width (signed two's complement)
- OWIDTH, 16, output sample width (signed)
- SHIFT, 15, arithmetic right shift applied before saturation
- AWIDTH, 7, FIFO address width; depth = 2**AWIDTH = 128
- PRIME_LEVEL, 64, fill level required before output starts (one hop)

Ports:
- clk  in  1  system clock, all logic rising-edge
- n_rst  in  1  asynchronous active-low reset
- din  in  DWIDTH  overlap-added sample (signed)
- din_valid  in  1  write strobe, connected to ready_hn2finish
- sample_tick  in  1  one-cycle audio-rate read request
- clr_flags  in  1  synchronous clear of sticky flags
- dout  out  OWIDTH  scaled, saturated output sample
- dout_valid  out  1  one-cycle pulse, dout updated
- level  out  AWIDTH+1  current FIFO occupancy, 0..128
- running  out  1  high in RUN state
- overflow  out  1  sticky: write dropped because FIFO full
- underflow  out  1  sticky: tick arrived in RUN with FIFO empty

Behaviour:
- Reset: async assert on n_rst low.
  - wr_ptr, rd_ptr, level = 0; state = PRIME.
  - dout = 0; dout_valid, running, overflow, underflow = 0.
  - Memory contents are not reset.
- Write:
  - din_valid & (level < 128) -> mem[wr_ptr] <= din, wr_ptr++ (wraps 127->0).
  - din_valid & full & no simultaneous pop -> sample dropped, overflow <= 1.
- States:
  - PRIME: ticks are ignored (no pop, dout_valid = 0, dout holds). Go to RUN when level >= PRIME_LEVEL, evaluated on the registered level, taking effect the next cycle.
  - RUN: running = 1.
    - sample_tick & !empty -> pop mem[rd_ptr], rd_ptr++ (wraps); dout registered next cycle, dout_valid = 1 for that cycle.
    - sample_tick & empty -> dout <= 0, dout_valid = 1, underflow <= 1, state -> PRIME.
- Latency: tick at cycle N -> dout/dout_valid valid at N+1. Write at N is visible to a read from N+1 onward; no same-cycle pass-through when empty.
- Simultaneous push and pop in RUN:
  - level unchanged.
  - When full, the pop frees a slot, so the write is accepted and overflow is not set.
- Scaling:
  - s = din >>> SHIFT (sign-preserving).
  - If s > 2**(OWIDTH-1)-1 -> 32767.
  - If s < -2**(OWIDTH-1) -> -32768.
  - Otherwise truncate to OWIDTH.
  - Computed on the read path, registered into dout.
- level: registered, updated every cycle by +1 (push only), -1 (pop only), 0 (both or neither). Never exceeds 128 or goes below 0.
- Flags:
  - clr_flags clears overflow/underflow the next cycle.
  - If a set event coincides with clr_flags, set wins.
- Reset mid-operation: immediate return to PRIME, empty FIFO. In-flight dout_valid is cancelled.
- Back-to-back ticks (every cycle) are legal. Each consumes one sample.

Test Plan:
- Reset then idle, 20 ticks -> dout = 0, dout_valid never asserted, running = 0, level = 0.
- Write 64 samples (din = k<<15, k = 0..63), then ticks -> running rises 1 cycle after level reaches 64; outputs 0,1,...,63 each 1 cycle after its tick; level returns to 0.
- Saturation: write din = 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_8000, 32'hFFFF_8000 (plus priming fill), drain -> dout = 32767, -32768, 1, -1.
- Overflow: 130 consecutive writes with no ticks -> level = 128, overflow = 1, samples 129/130 absent from drain order; write+tick in the same cycle while full -> level stays 128, overflow unchanged after clr_flags.
- Underflow: prime with 64, issue 65 ticks -> 65th tick gives dout = 0, dout_valid = 1, underflow = 1, running = 0; further ticks produce no dout_valid until 64 more writes.
- Wrap: 300 samples streamed with 1 write/cycle bursts and a tick every 3 cycles after priming, with no overflow -> output order matches input order across pointer wrap at 127->0. Then assert n_rst mid-stream -> all outputs/flags 0, level = 0, state PRIME.
